intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  DUT-side interrupt controller: the source end of the intr_if IREQ/IRQ protocol.
//  Collects 8 interrupt requests (IREQ[7:0]), latches pending bits (edge or level per source), masks them,
//  and drives the single IRQ line to the bench/CPU.
//  Software services it via a 4-register byte bus (pending W1C, mask, edge-select, vector).
// PARAMETERS
//  NSRC      8   number of request sources (1..8); bits >= NSRC read 0, never pend
//  RST_MASK  8'h00  MASK reset value (all sources masked)
// PORTS
//  wb_clk_i   in   1  clock; all logic on rising edge
//  wb_rst_i   in   1  synchronous reset, active high
//  IREQ       in   8  interrupt request lines, bit i = source i
//  addr       in   2  register address
//  wdata      in   8  write data
//  we         in   1  write strobe, one cycle per write
//  re         in   1  read strobe (qualifies rdata; no side effects)
//  rdata      out  8  read data, combinational from addr
//  IRQ        out  1  interrupt output, active high, registered
// BEHAVIOUR
//  Registers: 0 PEND (R/W1C), 1 MASK (RW, 1=enabled), 2 EDGE (RW, 1=rising-edge, 0=level), 3 VECT (RO).
//  VECT = {valid, 4'b0, idx[2:0]}; idx = lowest-numbered bit of PEND&MASK (bit 0 highest priority).
//  VECT = 8'h00 when none.
//  Reset: PEND=0, MASK=RST_MASK, EDGE=0, ireq_q=0, IRQ=0; rdata follows regs (0 at addr 0).
//  Reset held mid-operation discards all pending state; IREQ is ignored while wb_rst_i=1.
//  Edge detect: ireq_q <= IREQ each cycle; rise[i] = IREQ[i] & ~ireq_q[i].
//  After reset ireq_q=0, so a line already high counts as a rising edge on the first cycle.
//  PEND set: edge mode set on rise[i]; level mode set every cycle IREQ[i]=1.
//  PEND is set regardless of MASK; masking only gates IRQ/VECT.
//  PEND clear: write to addr 0 with wdata[i]=1 clears bit i.
//  Set and clear in the same cycle: set wins (the bit stays 1).
//  Level source still high after clear re-pends next edge.
//  IRQ <= |(PEND & MASK) (registered).
//  Latency: IREQ high sampled at edge N -> PEND at N -> IRQ at N+1.
//  Clear/mask at edge N -> IRQ low at N+1.
//  Writes to MASK/EDGE take effect for the cycle following the write edge; writes to addr 3 are ignored.
//  Changing EDGE 0->1 while a line is high does not create an edge (ireq_q already 1).
//  Reads: rdata valid the same cycle as addr. re is informational only; no read-clear.
// CONFIGURATION
//  INTR_CTRL_SYNC_EN defined: IREQ passes through a 2-flop synchroniser (reset 0) before edge detect/pend.
//   Adds 2 cycles: IREQ high at edge N -> PEND at N+2 -> IRQ at N+3.
//  Undefined: IREQ is used directly (synchronous sources only); latency as above.
// TESTING
//  1 Reset: assert wb_rst_i 2 cycles with IREQ=8'hFF -> IRQ=0, PEND=0, MASK=8'h00, EDGE=0 after release.
//  2 Edge: MASK=8'h08, EDGE=8'h08, pulse IREQ[3] 1 cycle -> PEND=8'h08, VECT=8'h83, IRQ=1 next cycle;
//    write PEND 8'h08 -> IRQ=0 next cycle.
//  3 Level: MASK=8'h01, EDGE=0, hold IREQ[0]=1, W1C 8'h01 -> PEND re-sets, IRQ stays 1;
//    drop IREQ[0] then W1C -> IRQ=0.
//  4 Priority/mask: pend bits 2 and 6 with MASK=8'hFF -> VECT=8'h82;
//    MASK=8'hFB -> VECT=8'h86; MASK=0 -> VECT=0, IRQ=0, PEND=8'h44.
//  5 Collision: edge source 5 rises in the same cycle as W1C 8'h20 -> PEND[5]=1 afterwards.
//  6 SYNC_EN build: IREQ[1] rise at edge N -> IRQ first high at edge N+3 (N+1 when undefined).

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: 8-source interrupt controller with pending/mask/edge/vector registers and a registered IRQ.
//   Define INTR_CTRL_SYNC_EN to pass IREQ through a 2-flop synchroniser before edge detect (+2 cycles).
module intr_ctrl #(
   parameter int         NSRC     = 8,
   parameter logic [7:0] RST_MASK = 8'h00
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic [7:0] IREQ,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   input  logic       we,
   input  logic       re,
   output logic [7:0] rdata,
   output logic       IRQ
);
   // Bits at or above NSRC never pend and always read back as zero.
   localparam logic [7:0] VMASK = 8'((9'h1 << NSRC) - 9'h1);

   logic [7:0] pend, mask, edge_sel, ireq_s, ireq_q, rise, set, clr, act, vect;
   logic [2:0] idx;
   logic       unused_re;

   // re only qualifies rdata for the reader; reads have no side effects.
   assign unused_re = re;

`ifdef INTR_CTRL_SYNC_EN
   logic [7:0] sync1, sync2;

   // Two-flop synchroniser for asynchronous request lines.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= IREQ;
         sync2 <= sync1;
      end
   end

   assign ireq_s = sync2;
`else
   assign ireq_s = IREQ;
`endif

   // Per-source set condition: rising edge in edge mode, high level in level mode; W1C from addr 0.
   always_comb begin
      rise = ireq_s & ~ireq_q;
      set  = ((edge_sel & rise) | (~edge_sel & ireq_s)) & VMASK;
      clr  = (we && addr == 2'd0) ? wdata : 8'h00;
      act  = pend & mask;
   end

   // Lowest-numbered active source wins the vector.
   always_comb begin
      idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (act[i]) idx = 3'(i);
      vect = (|act) ? {1'b1, 4'b0000, idx} : 8'h00;
   end

   // Register read mux, combinational from addr.
   always_comb begin
      rdata = (addr == 2'd0) ? pend :
              (addr == 2'd1) ? mask :
              (addr == 2'd2) ? edge_sel : vect;
   end

   // State update: set beats clear in the same cycle; IRQ lags PEND/MASK by one cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pend     <= 8'h00;
         mask     <= RST_MASK & VMASK;
         edge_sel <= 8'h00;
         ireq_q   <= 8'h00;
         IRQ      <= 1'b0;
      end else begin
         ireq_q <= ireq_s;
         pend   <= (pend & ~clr) | set;
         if (we && addr == 2'd1) mask <= wdata & VMASK;
         if (we && addr == 2'd2) edge_sel <= wdata & VMASK;
         IRQ    <= |act;
      end
   end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl.
module tb_intr_ctrl;
   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic [7:0] IREQ = 8'h00;
   logic [1:0] addr = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic       we = 1'b0;
   logic       re = 1'b0;
   logic [7:0] rdata;
   logic       IRQ;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] d;

`ifdef INTR_CTRL_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   intr_ctrl dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_i(wb_rst_i),
      .IREQ(IREQ),
      .addr(addr),
      .wdata(wdata),
      .we(we),
      .re(re),
      .rdata(rdata),
      .IRQ(IRQ)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v);
      addr = a;
      wdata = v;
      we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] v);
      addr = a;
      re = 1'b1;
      #1;
      v = rdata;
      re = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      IREQ = 8'hFF;
      tick();
      tick();
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", IRQ); end
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_pend got %h want 00", d); end
      IREQ = 8'h00;
      wb_rst_i = 1'b0;
      tick();
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_pend_after got %h want 00", d); end
      rd(2'd1, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_mask got %h want 00", d); end
      rd(2'd2, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_edge got %h want 00", d); end
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL rst_irq_after got %b want 0", IRQ); end
   endtask

   task automatic test_edge();
      wr(2'd1, 8'h08);
      wr(2'd2, 8'h08);
      IREQ = 8'h08;
      tick();
      IREQ = 8'h00;
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h08) begin n_err++; $display("FAIL edge_pend got %h want 08", d); end
      rd(2'd3, d);
      n_cmp++;
      if (d !== 8'h83) begin n_err++; $display("FAIL edge_vect got %h want 83", d); end
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL edge_irq_early got %b want 0", IRQ); end
      tick();
      n_cmp++;
      if (IRQ !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b want 1", IRQ); end
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h08) begin n_err++; $display("FAIL edge_pend_hold got %h want 08", d); end
      wr(2'd0, 8'h08);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL edge_w1c got %h want 00", d); end
      tick();
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL edge_irq_clr got %b want 0", IRQ); end
   endtask

   task automatic test_level();
      wr(2'd2, 8'h00);
      wr(2'd1, 8'h01);
      IREQ = 8'h01;
      tick();
      tick();
      n_cmp++;
      if (IRQ !== 1'b1) begin n_err++; $display("FAIL lvl_irq got %b want 1", IRQ); end
      wr(2'd0, 8'h01);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h01) begin n_err++; $display("FAIL lvl_repend got %h want 01", d); end
      tick();
      n_cmp++;
      if (IRQ !== 1'b1) begin n_err++; $display("FAIL lvl_irq_stay got %b want 1", IRQ); end
      IREQ = 8'h00;
      tick();
      wr(2'd0, 8'h01);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL lvl_clr got %h want 00", d); end
      tick();
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL lvl_irq_clr got %b want 0", IRQ); end
   endtask

   task automatic test_priority();
      wr(2'd1, 8'hFF);
      IREQ = 8'h44;
      tick();
      IREQ = 8'h00;
      rd(2'd3, d);
      n_cmp++;
      if (d !== 8'h82) begin n_err++; $display("FAIL prio_vect got %h want 82", d); end
      wr(2'd1, 8'hFB);
      rd(2'd3, d);
      n_cmp++;
      if (d !== 8'h86) begin n_err++; $display("FAIL prio_mask_vect got %h want 86", d); end
      wr(2'd1, 8'h00);
      rd(2'd3, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL prio_none_vect got %h want 00", d); end
      tick();
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL prio_irq got %b want 0", IRQ); end
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h44) begin n_err++; $display("FAIL prio_pend got %h want 44", d); end
      wr(2'd3, 8'hFF);
      rd(2'd3, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL vect_ro got %h want 00", d); end
      wr(2'd0, 8'hFF);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL prio_clr got %h want 00", d); end
   endtask

   task automatic test_collision();
      wr(2'd2, 8'h20);
      wr(2'd1, 8'h20);
      IREQ = 8'h20;
      wr(2'd0, 8'h20);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h20) begin n_err++; $display("FAIL coll_set_wins got %h want 20", d); end
      wr(2'd0, 8'h20);
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL coll_no_reedge got %h want 00", d); end
      wr(2'd2, 8'h21);
      IREQ = 8'h21;
      tick();
      wr(2'd0, 8'h01);
      tick();
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL edge_held_high got %h want 00", d); end
      IREQ = 8'h00;
      tick();
   endtask

   task automatic test_latency();
      int n;
      wr(2'd2, 8'h02);
      wr(2'd1, 8'h02);
      wr(2'd0, 8'hFF);
      tick();
      tick();
      IREQ = 8'h02;
      n = 0;
      while (IRQ !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      IREQ = 8'h00;
      n_cmp++;
      if (n !== LAT) begin n_err++; $display("FAIL latency got %0d want %0d", n, LAT); end
   endtask

   task automatic test_reset_mid();
      IREQ = 8'h10;
      wr(2'd1, 8'h10);
      wb_rst_i = 1'b1;
      tick();
      IREQ = 8'h00;
      wb_rst_i = 1'b0;
      tick();
      rd(2'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL midrst_pend got %h want 00", d); end
      rd(2'd1, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL midrst_mask got %h want 00", d); end
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL midrst_irq got %b want 0", IRQ); end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_level();
      test_priority();
      test_collision();
      test_latency();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
